// File: rtl/sisc_ifetch.sv
// SISC instruction fetch stage: PC, IR, imem request/ack handshake, branch load and field decode.
// Optional imem ack timeout is built when IFETCH_TIMEOUT_EN is defined.
module sisc_ifetch #(
  parameter int unsigned PC_W    = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic            fetch_req,
  input  logic            br_load,
  input  logic            br_rel,
  input  logic [PC_W-1:0] br_addr,
  input  logic [PC_W-1:0] br_off,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [3:0]      opcode,
  output logic [3:0]      mm,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      rt,
  output logic [15:0]     imm,
  output logic [PC_W-1:0] pc,
  output logic            ir_valid,
  output logic            busy,
  output logic            halted,
  output logic            fetch_err
);

  localparam int unsigned IR_W   = 32;
  localparam logic [3:0]  OP_HLT = 4'hF;
  localparam logic [0:0]  S_IDLE = 1'b0;
  localparam logic [0:0]  S_WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            imem_req_q, imem_req_d;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic            halted_q, halted_d;
  logic            pend_fetch_q, pend_fetch_d;
  logic            pend_br_q, pend_br_d;
  logic            pend_rel_q, pend_rel_d;
  logic [PC_W-1:0] pend_addr_q, pend_addr_d;
  logic [PC_W-1:0] pend_off_q, pend_off_d;

  logic [PC_W-1:0] br_tgt;
  logic            want_fetch;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fetch_err_q, fetch_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  // A live br_load takes precedence over one captured during the previous WAIT.
  assign br_tgt = br_load ? (br_rel ? pc_q + br_off : br_addr)
                          : (pend_rel_q ? pc_q + pend_off_q : pend_addr_q);
  assign want_fetch = (fetch_req | pend_fetch_q) & ~halted_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    imem_req_d   = imem_req_q;
    imem_addr_d  = imem_addr_q;
    halted_d     = halted_q;
    pend_fetch_d = pend_fetch_q;
    pend_br_d    = pend_br_q;
    pend_rel_d   = pend_rel_q;
    pend_addr_d  = pend_addr_q;
    pend_off_d   = pend_off_q;
`ifdef IFETCH_TIMEOUT_EN
    cnt_d        = cnt_q;
    fetch_err_d  = fetch_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        pend_br_d = 1'b0;
        if (br_load || pend_br_q) begin
          // Branch wins this cycle; any fetch is deferred so it uses the new PC.
          pc_d         = br_tgt;
          pend_fetch_d = want_fetch;
        end else begin
          pend_fetch_d = 1'b0;
          if (want_fetch) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_q;
            state_d     = S_WAIT;
`ifdef IFETCH_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        if (br_load) begin
          pend_br_d   = 1'b1;
          pend_rel_d  = br_rel;
          pend_addr_d = br_addr;
          pend_off_d  = br_off;
        end
        if (imem_ack) begin
          ir_d       = imem_rdata;
          pc_d       = pc_q + PC_W'(1);
          ir_valid_d = 1'b1;
          imem_req_d = 1'b0;
          state_d    = S_IDLE;
          if (imem_rdata[31:28] == OP_HLT) begin
            halted_d = 1'b1;
          end
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          ir_d        = '0;
          ir_valid_d  = 1'b1;
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      halted_q     <= 1'b0;
      pend_fetch_q <= 1'b0;
      pend_br_q    <= 1'b0;
      pend_rel_q   <= 1'b0;
      pend_addr_q  <= '0;
      pend_off_q   <= '0;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q        <= '0;
      fetch_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      halted_q     <= halted_d;
      pend_fetch_q <= pend_fetch_d;
      pend_br_q    <= pend_br_d;
      pend_rel_q   <= pend_rel_d;
      pend_addr_q  <= pend_addr_d;
      pend_off_q   <= pend_off_d;
`ifdef IFETCH_TIMEOUT_EN
      cnt_q        <= cnt_d;
      fetch_err_q  <= fetch_err_d;
`endif
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign pc        = pc_q;
  assign ir_valid  = ir_valid_q;
  assign busy      = (state_q == S_WAIT);
  assign halted    = halted_q;
  assign opcode    = ir_q[31:28];
  assign mm        = ir_q[27:24];
  assign rd        = ir_q[23:20];
  assign rs        = ir_q[19:16];
  assign rt        = ir_q[15:12];
  assign imm       = ir_q[15:0];
`ifdef IFETCH_TIMEOUT_EN
  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_ifetch.sv
// Testbench for sisc_ifetch: directed scenarios plus randomized fetch/branch traffic
// checked against a PC model kept as plain arithmetic.
module tb_sisc_ifetch;

  localparam int unsigned PC_W = 16;
  localparam int unsigned TMO  = 15;

  logic            clk = 1'b0;
  logic            rst_f;
  logic            fetch_req;
  logic            br_load;
  logic            br_rel;
  logic [PC_W-1:0] br_addr;
  logic [PC_W-1:0] br_off;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [3:0]      opcode, mm, rd, rs, rt;
  logic [15:0]     imm;
  logic [PC_W-1:0] pc;
  logic            ir_valid, busy, halted, fetch_err;

  int vec = 0;
  int err = 0;
  logic [15:0] pc_m;

  always #5 clk = ~clk;

  sisc_ifetch #(.PC_W(PC_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_f(rst_f), .fetch_req(fetch_req), .br_load(br_load), .br_rel(br_rel),
    .br_addr(br_addr), .br_off(br_off), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .opcode(opcode), .mm(mm), .rd(rd),
    .rs(rs), .rt(rt), .imm(imm), .pc(pc), .ir_valid(ir_valid), .busy(busy),
    .halted(halted), .fetch_err(fetch_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_f = 1'b0;
    @(negedge clk);
    rst_f = 1'b1;
    step();
    pc_m = 16'h0000;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] d;
    d = $urandom;
    d[31:28] = 4'($urandom_range(0, 14));
    return d;
  endfunction

  // Pulse fetch_req, report what the request looked like, then ack after dly wait cycles.
  task automatic fetch_cycle(input logic [31:0] data, input int dly,
                             output logic [15:0] addr_seen, output logic req_seen);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    req_seen  = imem_req;
    addr_seen = imem_addr;
    repeat (dly) step();
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    rst_f = 1'b0; fetch_req = 1'b0; br_load = 1'b0; br_rel = 1'b0;
    br_addr = '0; br_off = '0; imem_ack = 1'b0; imem_rdata = '0;
    #12;
    vec++;
    if ({imem_req, imem_addr, pc, ir_valid, busy, halted, fetch_err} !== '0) begin
      err++;
      $display("FAIL reset_ctrl got req=%b addr=%h pc=%h v=%b busy=%b h=%b e=%b exp all 0",
               imem_req, imem_addr, pc, ir_valid, busy, halted, fetch_err);
    end
    vec++;
    if ({opcode, mm, rd, rs, rt, imm} !== '0) begin
      err++;
      $display("FAIL reset_fields got op=%h mm=%h rd=%h rs=%h rt=%h imm=%h exp 0",
               opcode, mm, rd, rs, rt, imm);
    end
    @(negedge clk);
    rst_f = 1'b1;
    step();
    pc_m = 16'h0000;
  endtask

  task automatic test_basic_fetch();
    logic [15:0] a;
    logic        r;
    fetch_cycle(32'h81230005, 0, a, r);
    vec++;
    if (r !== 1'b1 || a !== 16'h0000) begin
      err++; $display("FAIL basic_req got req=%b addr=%h exp req=1 addr=0000", r, a);
    end
    vec++;
    if ({opcode, mm, rd, rs, imm} !== {4'h8, 4'h1, 4'h2, 4'h3, 16'h0005}) begin
      err++; $display("FAIL basic_decode got op=%h mm=%h rd=%h rs=%h imm=%h exp 8 1 2 3 0005",
                      opcode, mm, rd, rs, imm);
    end
    vec++;
    if (pc !== 16'h0001 || ir_valid !== 1'b1 || imem_req !== 1'b0) begin
      err++; $display("FAIL basic_state got pc=%h v=%b req=%b exp pc=0001 v=1 req=0",
                      pc, ir_valid, imem_req);
    end
    pc_m = 16'h0001;
  endtask

  task automatic test_branch();
    logic [15:0] a;
    logic        r;
    br_load = 1'b1; br_rel = 1'b0; br_addr = 16'h0040;
    step();
    br_load = 1'b0;
    vec++;
    if (pc !== 16'h0040) begin
      err++; $display("FAIL br_abs got pc=%h exp 0040", pc);
    end
    fetch_cycle(rand_instr(), 0, a, r);
    vec++;
    if (r !== 1'b1 || a !== 16'h0040 || pc !== 16'h0041) begin
      err++; $display("FAIL br_abs_fetch got req=%b addr=%h pc=%h exp 1 0040 0041", r, a, pc);
    end
    br_load = 1'b1; br_rel = 1'b1; br_off = 16'hFFFE;
    step();
    br_load = 1'b0;
    vec++;
    if (pc !== 16'h003F) begin
      err++; $display("FAIL br_rel got pc=%h exp 003f", pc);
    end
    pc_m = 16'h003F;
  endtask

  task automatic test_br_with_fetch();
    br_load = 1'b1; br_rel = 1'b0; br_addr = 16'h1234; fetch_req = 1'b1;
    step();
    br_load = 1'b0; fetch_req = 1'b0;
    vec++;
    if (imem_req !== 1'b0 || pc !== 16'h1234) begin
      err++; $display("FAIL brf_first got req=%b pc=%h exp req=0 pc=1234", imem_req, pc);
    end
    step();
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h1234) begin
      err++; $display("FAIL brf_issue got req=%b addr=%h exp req=1 addr=1234", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = rand_instr();
    step();
    imem_ack = 1'b0;
    vec++;
    if (pc !== 16'h1235) begin
      err++; $display("FAIL brf_ack got pc=%h exp 1235", pc);
    end
    pc_m = 16'h1235;
  endtask

  task automatic test_br_in_wait();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    br_load = 1'b1; br_rel = 1'b1; br_off = 16'h0010;
    step();
    br_load = 1'b0;
    step();
    imem_ack = 1'b1; imem_rdata = rand_instr();
    step();
    imem_ack = 1'b0;
    vec++;
    if (pc !== pc_m + 16'd1) begin
      err++; $display("FAIL brw_inc got pc=%h exp %h", pc, pc_m + 16'd1);
    end
    step();
    pc_m = pc_m + 16'd1 + 16'h0010;
    vec++;
    if (pc !== pc_m) begin
      err++; $display("FAIL brw_target got pc=%h exp %h", pc, pc_m);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] a;
    logic        r;
    br_load = 1'b1; br_rel = 1'b0; br_addr = 16'hFFFF;
    step();
    br_load = 1'b0;
    fetch_cycle(rand_instr(), 1, a, r);
    vec++;
    if (a !== 16'hFFFF || pc !== 16'h0000) begin
      err++; $display("FAIL wrap_inc got addr=%h pc=%h exp ffff 0000", a, pc);
    end
    br_load = 1'b1; br_rel = 1'b0; br_addr = 16'hFFFE;
    step();
    br_rel = 1'b1; br_off = 16'h0005;
    step();
    br_load = 1'b0;
    vec++;
    if (pc !== 16'h0003) begin
      err++; $display("FAIL wrap_rel got pc=%h exp 0003", pc);
    end
    pc_m = 16'h0003;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [15:0] ba, bo, wa, wo;
    logic        rel, wrel, wbr;
    int          mode, dly;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      dly  = $urandom_range(0, 4);
      d    = rand_instr();
      rel  = 1'($urandom_range(0, 1));
      wrel = 1'($urandom_range(0, 1));
      wbr  = 1'($urandom_range(0, 1));
      ba = 16'($urandom); bo = 16'($urandom);
      wa = 16'($urandom); wo = 16'($urandom);
      if (mode != 0) begin
        br_load = 1'b1; br_rel = rel; br_addr = ba; br_off = bo;
        fetch_req = (mode == 3);
        pc_m = rel ? pc_m + bo : ba;
        step();
        br_load = 1'b0; fetch_req = 1'b0;
      end
      if (mode != 3) begin
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
      end else begin
        step();
      end
      vec++;
      if (imem_req !== 1'b1 || imem_addr !== pc_m) begin
        err++; $display("FAIL rnd_req it=%0d got req=%b addr=%h exp req=1 addr=%h",
                        it, imem_req, imem_addr, pc_m);
      end
      br_load = wbr; br_rel = wrel; br_addr = wa; br_off = wo;
      for (int k = 0; k <= dly; k++) begin
        imem_ack = (k == dly);
        imem_rdata = d;
        step();
        br_load = 1'b0;
        imem_ack = 1'b0;
      end
      pc_m = pc_m + 16'd1;
      vec++;
      if (pc !== pc_m || {opcode, mm, rd, rs, imm} !== d || rt !== d[15:12] ||
          ir_valid !== 1'b1 || imem_req !== 1'b0) begin
        err++; $display("FAIL rnd_ack it=%0d got pc=%h ir=%h%h%h%h%h v=%b req=%b exp pc=%h ir=%h",
                        it, pc, opcode, mm, rd, rs, imm, ir_valid, imem_req, pc_m, d);
      end
      if (wbr) begin
        step();
        pc_m = wrel ? pc_m + wo : wa;
        vec++;
        if (pc !== pc_m) begin
          err++; $display("FAIL rnd_wbr it=%0d got pc=%h exp %h", it, pc, pc_m);
        end
      end
    end
  endtask

  task automatic test_timeout();
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    repeat (TMO - 1) step();
    vec++;
    if (imem_req !== 1'b1) begin
      err++; $display("FAIL tmo_early got req=%b exp 1", imem_req);
    end
    step();
    vec++;
    if (imem_req !== 1'b0 || fetch_err !== 1'b1 || opcode !== 4'h0 || imm !== 16'h0000 ||
        ir_valid !== 1'b1 || pc !== pc_m || busy !== 1'b0) begin
      err++; $display("FAIL tmo_fire got req=%b err=%b op=%h imm=%h v=%b pc=%h busy=%b exp 0 1 0 0000 1 %h 0",
                      imem_req, fetch_err, opcode, imm, ir_valid, pc, busy, pc_m);
    end
`else
    repeat (3 * TMO) step();
    vec++;
    if (imem_req !== 1'b1 || busy !== 1'b1 || fetch_err !== 1'b0) begin
      err++; $display("FAIL wait_hold got req=%b busy=%b err=%b exp 1 1 0", imem_req, busy, fetch_err);
    end
    imem_ack = 1'b1; imem_rdata = rand_instr();
    step();
    imem_ack = 1'b0;
    pc_m = pc_m + 16'd1;
    vec++;
    if (pc !== pc_m || imem_req !== 1'b0) begin
      err++; $display("FAIL wait_ack got pc=%h req=%b exp %h 0", pc, imem_req, pc_m);
    end
`endif
  endtask

  task automatic test_halt();
    logic [15:0] a;
    logic        r;
    fetch_cycle(32'hF0000000, 0, a, r);
    pc_m = pc_m + 16'd1;
    vec++;
    if (halted !== 1'b1 || opcode !== 4'hF || pc !== pc_m) begin
      err++; $display("FAIL halt_set got h=%b op=%h pc=%h exp 1 f %h", halted, opcode, pc, pc_m);
    end
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== pc_m) begin
        err++; $display("FAIL halt_block k=%0d got req=%b busy=%b pc=%h exp 0 0 %h",
                        k, imem_req, busy, pc, pc_m);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    vec++;
    if (halted !== 1'b0) begin
      err++; $display("FAIL rst_halt_clr got %b exp 0", halted);
    end
    br_load = 1'b1; br_rel = 1'b0; br_addr = 16'h0777;
    step();
    br_load = 1'b0;
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    vec++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0777) begin
      err++; $display("FAIL rstw_pre got req=%b addr=%h exp 1 0777", imem_req, imem_addr);
    end
    step();
    #2;
    rst_f = 1'b0;
    #1;
    vec++;
    if ({imem_req, imem_addr, pc, ir_valid, busy, halted, fetch_err} !== '0 ||
        {opcode, mm, rd, rs, rt, imm} !== '0) begin
      err++; $display("FAIL rstw_async got req=%b addr=%h pc=%h v=%b busy=%b op=%h exp all 0",
                      imem_req, imem_addr, pc, ir_valid, busy, opcode);
    end
    @(negedge clk);
    rst_f = 1'b1;
    step();
    imem_ack = 1'b1; imem_rdata = 32'h81230005;
    step();
    imem_ack = 1'b0;
    vec++;
    if (ir_valid !== 1'b0 || opcode !== 4'h0 || pc !== 16'h0000 || imem_req !== 1'b0) begin
      err++; $display("FAIL rstw_stale_ack got v=%b op=%h pc=%h req=%b exp 0 0 0000 0",
                      ir_valid, opcode, pc, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_branch();
    test_br_with_fetch();
    test_br_in_wait();
    test_wrap();
    test_random();
    test_timeout();
    test_halt();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/sisc_ifetch.md
# sisc_ifetch

Instruction fetch stage for the SISC computer, directly upstream of the control FSM. Holds the program counter and instruction register, runs a request/acknowledge read to instruction memory when the control FSM requests a fetch, and decodes the latched instruction into the `opcode`/`mm`/register/immediate fields that the control FSM and datapath consume. It applies branch targets computed by the control FSM and stops fetching after a `HLT` is latched.

## Interface
- `PC_W`, default 16 – program counter and instruction memory address width.
- `TIMEOUT`, default 15 – maximum wait cycles for `imem_ack`; used only with `IFETCH_TIMEOUT_EN`.
- `clk` in 1 – single clock; all state changes on the rising edge.
- `rst_f` in 1 – asynchronous, active-low reset.
- `fetch_req` in 1 – one-cycle pulse from the control FSM in its fetch state.
- `br_load` in 1 – one-cycle pulse: load a branch target into the PC.
- `br_rel` in 1 – 1 = relative (PC + `br_off`), 0 = absolute (`br_addr`).
- `br_addr` in `PC_W` – absolute branch target.
- `br_off` in `PC_W` – two's-complement relative offset.
- `imem_req` out 1 – read request, registered, held until acknowledged.
- `imem_addr` out `PC_W` – read address, registered, stable while `imem_req` is high.
- `imem_ack` in 1 – read data valid this cycle.
- `imem_rdata` in 32 – instruction word.
- `opcode` out 4 – IR[31:28].
- `mm` out 4 – IR[27:24].
- `rd` out 4 – IR[23:20].
- `rs` out 4 – IR[19:16].
- `rt` out 4 – IR[15:12].
- `imm` out 16 – IR[15:0].
- `pc` out `PC_W` – current PC.
- `ir_valid` out 1 – IR holds a fetched instruction.
- `busy` out 1 – high while in WAIT.
- `halted` out 1 – sticky; a `HLT` (opcode 15) has been latched.
- `fetch_err` out 1 – sticky timeout flag; constant 0 without `IFETCH_TIMEOUT_EN`.

## Operation
- Reset (async, `rst_f` low): state IDLE, `pc`=0, IR=0, `ir_valid`=0, `imem_req`=0, `imem_addr`=0, `halted`=0, `fetch_err`=0, pending branch cleared. All decoded fields therefore read 0 (NOOP).
- IDLE:
  - If `fetch_req` and not `halted`: set `imem_req`=1, `imem_addr`=`pc`, go to WAIT.
  - If `br_load`: `pc` ← `br_rel` ? `pc`+`br_off` : `br_addr`.
  - If `br_load` and `fetch_req` arrive together: apply the branch, hold the fetch as pending, and issue it the next cycle from the new PC.
- WAIT:
  - On `imem_ack`: IR ← `imem_rdata`, `pc` ← `pc`+1, `ir_valid`=1, `imem_req`=0, go to IDLE.
  - If the new opcode is 15, set `halted`.
- `br_load` during WAIT is captured as pending and applied in the cycle after the ack. It overrides the increment target and is relative to the incremented PC.
- `fetch_req` during WAIT or while `halted` is ignored.
- Arithmetic is modulo 2^`PC_W`: 0xFFFF+1 → 0x0000; relative add wraps the same way.
- The PC after a fetch is the branch instruction's address + 1. BRR offsets are relative to that value.

## Timing
- `fetch_req` sampled at edge n → `imem_req`/`imem_addr` valid after edge n.
- `imem_ack` sampled high at edge m → IR, `pc`, and `ir_valid` update and `imem_req` falls after edge m. Minimum fetch latency is 2 cycles (ack in the first request cycle).
- Decoded fields are combinational from IR and stable from edge m until the next ack.
- `br_load` in IDLE: new PC visible after the same edge.
- Reset mid-WAIT: `imem_req` drops immediately (asynchronously), and any in-flight ack after reset release is ignored.

## Configuration
- `IFETCH_TIMEOUT_EN` defined:
  - A counter runs in WAIT. If `TIMEOUT` cycles pass without `imem_ack`, drop `imem_req`, load IR with 0 (NOOP), set `ir_valid`=1 and sticky `fetch_err`, leave `pc` unchanged, and return to IDLE.
  - The counter clears on each new request.
- `IFETCH_TIMEOUT_EN` undefined: WAIT persists until `imem_ack`, no counter is built, and `fetch_err` is tied 0.

## Test plan
- Reset then `fetch_req`, ack one cycle later with 0x81230005 → `imem_addr`=0, `opcode`=8, `mm`=1, `rd`=2, `rs`=3, `imm`=0x0005, `pc`=1, `ir_valid`=1.
- `br_load`, `br_rel`=0, `br_addr`=0x0040 in IDLE, then fetch → `imem_addr`=0x0040. Relative with `pc`=0x0041, `br_off`=0xFFFE → `pc`=0x003F.
- `br_load` together with `fetch_req` → request issued one cycle later with `imem_addr`=`br_addr`. `br_load` during WAIT → after ack, `pc`=target, not +1.
- `pc`=0xFFFF, fetch acked → `pc`=0x0000. Ack 0xF0000000 → `halted`=1, and later `fetch_req` produces no `imem_req`.
- With `IFETCH_TIMEOUT_EN`, no ack for 15 cycles → `imem_req` low, `fetch_err`=1, `opcode`=0, `pc` unchanged.
- Assert `rst_f` low mid-WAIT → `imem_req`=0 immediately and all outputs at their reset values.
